// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
// Byte1 field positions follow the standard 3-byte PS/2 packet.
package mouse_pkg;

   typedef enum logic [1:0] {
      WAIT_B1,
      WAIT_B2,
      WAIT_B3,
      UPDATE
   } state_t;

   localparam int B1_LEFT  = 0;
   localparam int B1_RIGHT = 1;
   localparam int B1_SYNC  = 3;
   localparam int B1_XS    = 4;
   localparam int B1_YS    = 5;
   localparam int B1_XOV   = 6;
   localparam int B1_YOV   = 7;

   localparam int H_DEF = 640;
   localparam int V_DEF = 480;

endpackage

// File: rtl/mouse_axis_update.sv
// One axis of the cursor: add a signed 9-bit delta to the current
// position and clamp the result to [0, MAX-1].
module mouse_axis_update #(
   parameter int MAX = 640
) (
   input  logic [9:0] pos,
   input  logic [8:0] delta,
   input  logic       ovf,
   input  logic       neg,
   output logic [9:0] pos_next
);

   localparam logic signed [10:0] LIM = 11'(MAX - 1);

   logic signed [10:0] d;
   logic signed [10:0] sum;

   always_comb begin
      d = ovf ? 11'sd0 : $signed({{2{delta[8]}}, delta});
      // screen Y grows downward, so the Y axis subtracts
      if (neg) d = -d;
      sum = $signed({1'b0, pos}) + d;
      if (sum < 11'sd0)
         pos_next = '0;
      else if (sum > LIM)
         pos_next = LIM[9:0];
      else
         pos_next = sum[9:0];
   end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and accumulates the deltas
// into a saturated absolute cursor position.
module mouse_tracker
   import mouse_pkg::*;
#(
   parameter int H_MAX       = H_DEF,
   parameter int V_MAX       = V_DEF,
   parameter int X_INIT      = 320,
   parameter int Y_INIT      = 240,
   parameter int TIMEOUT_CYC = 1250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done_tick,
   output logic [9:0] mouse_x,
   output logic [9:0] mouse_y,
   output logic       btn_left,
   output logic       btn_right,
   output logic       pkt_tick,
   output logic       sync_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

   state_t state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [7:0] b1, b1_n;
   logic [7:0] b2, b2_n;
   logic [7:0] b3, b3_n;
   logic [9:0] x_n, y_n;
   logic [9:0] x_nxt, y_nxt;
   logic bl_n, br_n, pkt_n, err_n;

   mouse_axis_update #(.MAX(H_MAX)) u_x (
      .pos      (mouse_x),
      .delta    ({b1[B1_XS], b2}),
      .ovf      (b1[B1_XOV]),
      .neg      (1'b0),
      .pos_next (x_nxt)
   );

   mouse_axis_update #(.MAX(V_MAX)) u_y (
      .pos      (mouse_y),
      .delta    ({b1[B1_YS], b3}),
      .ovf      (b1[B1_YOV]),
      .neg      (1'b1),
      .pos_next (y_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= WAIT_B1;
         timer     <= '0;
         b1        <= '0;
         b2        <= '0;
         b3        <= '0;
         mouse_x   <= 10'(X_INIT);
         mouse_y   <= 10'(Y_INIT);
         btn_left  <= 1'b0;
         btn_right <= 1'b0;
         pkt_tick  <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         b1        <= b1_n;
         b2        <= b2_n;
         b3        <= b3_n;
         mouse_x   <= x_n;
         mouse_y   <= y_n;
         btn_left  <= bl_n;
         btn_right <= br_n;
         pkt_tick  <= pkt_n;
         sync_err  <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      b1_n    = b1;
      b2_n    = b2;
      b3_n    = b3;
      x_n     = mouse_x;
      y_n     = mouse_y;
      bl_n    = btn_left;
      br_n    = btn_right;
      pkt_n   = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         WAIT_B1, UPDATE: begin
            if (state == UPDATE) begin
               x_n     = x_nxt;
               y_n     = y_nxt;
               bl_n    = b1[B1_LEFT];
               br_n    = b1[B1_RIGHT];
               pkt_n   = 1'b1;
               state_n = WAIT_B1;
            end
            if (rx_done_tick) begin
               if (rx_data[B1_SYNC]) begin
                  b1_n    = rx_data;
                  timer_n = '0;
                  state_n = WAIT_B2;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         WAIT_B2, WAIT_B3: begin
            if (rx_done_tick) begin
               timer_n = '0;
               if (state == WAIT_B2) begin
                  b2_n    = rx_data;
                  state_n = WAIT_B3;
               end else begin
                  b3_n    = rx_data;
                  state_n = UPDATE;
               end
            end else if (timer == TLAST) begin
               timer_n = '0;
               err_n   = 1'b1;
               state_n = WAIT_B1;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         default: state_n = WAIT_B1;
      endcase
   end

endmodule
